// File: rtl/frame_downscale_2x2_if.sv
// Registered RGB565 pixel stream from the camera capture stage.
// master: capture stage driving pixels; slave: downstream consumer.
interface frame_downscale_2x2_if;
  logic        frame_valid;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [15:0] pixel_data;

  modport master (
    output frame_valid,
    output pixel_valid,
    output pixel_x,
    output pixel_y,
    output pixel_data
  );

  modport slave (
    input frame_valid,
    input pixel_valid,
    input pixel_x,
    input pixel_y,
    input pixel_data
  );
endinterface

// File: rtl/frame_downscale_2x2.sv
// 2x2 box-average downscaler for an RGB565 pixel stream; writes a quarter-size
// frame through an address/data/enable port and flags each frame's completion.
module frame_downscale_2x2 #(
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480,
  parameter int ADDR_W = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_downscale_2x2_if.slave pix,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [15:0]          wr_data,
  output logic                 frame_done,
  output logic                 frame_short,
  output logic [7:0]           frame_count
);

  localparam int HALF_W = SRC_W / 2;
  localparam int TOTAL  = SRC_W * SRC_H / 4;
  localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [ADDR_W-1:0] HALF_W_A = ADDR_W'(HALF_W);
  localparam logic [ADDR_W:0]   TOTAL_C  = (ADDR_W + 1)'(TOTAL);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  logic [1:0] state;

  logic       accept;
  logic       odd_x;
  logic [4:0] in_r;
  logic [5:0] in_g;
  logic [4:0] in_b;
  logic [4:0] pair_r;
  logic [5:0] pair_g;
  logic [4:0] pair_b;
  logic [5:0] hsum_r;
  logic [6:0] hsum_g;
  logic [5:0] hsum_b;

  logic        s1_valid;
  logic        s1_odd_y;
  logic [18:0] s1_hsum;
  logic [8:0]  s1_xh;
  logic [8:0]  s1_yh;

  logic [18:0]      lb_mem [HALF_W];
  logic [18:0]      lb_rd;
  logic [LB_AW-1:0] lb_rd_idx;
  logic [LB_AW-1:0] lb_wr_idx;

  logic [6:0]        vsum_r;
  logic [7:0]        vsum_g;
  logic [6:0]        vsum_b;
  logic [7:0]        rnd_r;
  logic [8:0]        rnd_g;
  logic [7:0]        rnd_b;
  logic [ADDR_W-1:0] blk_addr;

  logic [ADDR_W:0] wr_cnt;
  logic [ADDR_W:0] cnt_next;

  // Acceptance gate and horizontal pairing
  always_comb begin
    accept = (state == ACTIVE) && pix.pixel_valid && pix.frame_valid
          && ({1'b0, pix.pixel_x} < 11'(SRC_W))
          && ({1'b0, pix.pixel_y} < 11'(SRC_H));
    odd_x  = pix.pixel_x[0];
    in_r   = pix.pixel_data[15:11];
    in_g   = pix.pixel_data[10:5];
    in_b   = pix.pixel_data[4:0];
    hsum_r = {1'b0, pair_r} + {1'b0, in_r};
    hsum_g = {1'b0, pair_g} + {1'b0, in_g};
    hsum_b = {1'b0, pair_b} + {1'b0, in_b};
  end

  assign lb_rd_idx = pix.pixel_x[LB_AW:1];
  assign lb_wr_idx = s1_xh[LB_AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_r   <= '0;
      pair_g   <= '0;
      pair_b   <= '0;
      s1_valid <= 1'b0;
      s1_odd_y <= 1'b0;
      s1_hsum  <= '0;
      s1_xh    <= '0;
      s1_yh    <= '0;
    end else begin
      s1_valid <= accept && odd_x;
      if (accept && !odd_x) begin
        pair_r <= in_r;
        pair_g <= in_g;
        pair_b <= in_b;
      end
      if (accept && odd_x) begin
        s1_odd_y <= pix.pixel_y[0];
        s1_hsum  <= {hsum_r, hsum_g, hsum_b};
        s1_xh    <= pix.pixel_x[9:1];
        s1_yh    <= pix.pixel_y[9:1];
      end
    end
  end

  // Line buffer of even-row partial sums: read issued with the odd-row pixel,
  // even-row sum written one cycle after its pixel. Rows never overlap in time.
  always_ff @(posedge clk) begin
    if (accept && odd_x && pix.pixel_y[0])
      lb_rd <= lb_mem[lb_rd_idx];
    if (s1_valid && !s1_odd_y)
      lb_mem[lb_wr_idx] <= s1_hsum;
  end

  always_comb begin
    vsum_r   = {1'b0, s1_hsum[18:13]} + {1'b0, lb_rd[18:13]};
    vsum_g   = {1'b0, s1_hsum[12:6]}  + {1'b0, lb_rd[12:6]};
    vsum_b   = {1'b0, s1_hsum[5:0]}   + {1'b0, lb_rd[5:0]};
    rnd_r    = {1'b0, vsum_r} + 8'd2;
    rnd_g    = {1'b0, vsum_g} + 9'd2;
    rnd_b    = {1'b0, vsum_b} + 8'd2;
    blk_addr = ADDR_W'(s1_yh) * HALF_W_A + ADDR_W'(s1_xh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= s1_valid && s1_odd_y;
      if (s1_valid && s1_odd_y) begin
        wr_addr <= blk_addr;
        wr_data <= {rnd_r[6:2], rnd_g[7:2], rnd_b[6:2]};
      end
    end
  end

  // Count includes a write landing in the same cycle, so the FLUSH-cycle
  // write is reflected in frame_short.
  assign cnt_next = (wr_en && (wr_cnt != '1)) ? wr_cnt + 1'b1 : wr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
      wr_cnt      <= cnt_next;
      case (state)
        IDLE: begin
          if (pix.frame_valid) begin
            state  <= ACTIVE;
            wr_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (!pix.frame_valid)
            state <= FLUSH;
        end
        FLUSH: begin
          state       <= IDLE;
          frame_done  <= 1'b1;
          frame_short <= (cnt_next != TOTAL_C);
          frame_count <= frame_count + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_downscale_2x2.md
# frame_downscale_2x2

Pixel-stream consumer that sits directly downstream of the camera pixel-capture stage, in the camera pixel-clock domain. It takes the registered RGB565 pixel stream (pixel_valid, pixel_x, pixel_y, pixel_data, frame_valid) and averages each 2x2 block into one RGB565 pixel, using a one-line buffer of partial sums. The result is written through a simple write port (address/data/enable) into a quarter-resolution frame buffer, with per-frame completion and integrity flags.

## Interface
- SRC_W, 640, source line width in pixels (even, ≤1024)
- SRC_H, 480, source frame height in lines (even, ≤1024)
- ADDR_W, 17, write-address width; must hold SRC_W*SRC_H/4-1
- clk  input  1  pixel clock (driven by cmos_pclk); all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- frame_valid  input  1  high for the duration of an accepted frame
- pixel_valid  input  1  one-cycle strobe, pixel fields valid
- pixel_x  input  10  source column
- pixel_y  input  10  source row
- pixel_data  input  16  RGB565 {R[15:11],G[10:5],B[4:0]}
- wr_en  output  1  one-cycle write strobe
- wr_addr  output  ADDR_W  destination address
- wr_data  output  16  averaged RGB565 pixel
- frame_done  output  1  one-cycle pulse at end of each frame
- frame_short  output  1  valid with frame_done: write count ≠ SRC_W*SRC_H/4
- frame_count  output  8  completed frames, wraps 255→0

## Operation
- State machine: IDLE → ACTIVE when frame_valid sampled high; ACTIVE → FLUSH when frame_valid sampled low; FLUSH → IDLE after one cycle, asserting frame_done on that transition. Entering ACTIVE clears the write counter.
- A pixel is accepted only when the state is ACTIVE, pixel_valid=1, frame_valid=1, pixel_x<SRC_W and pixel_y<SRC_H; all others are ignored entirely.
- Components are zero-extended: R 5b, G 6b, B 5b.
- Even x: the component values are held in a pair register (overwriting any previous value).
- Odd x: horizontal sums are formed with the held values (R 6b, G 7b, B 6b).
  - Even y: the 19-bit sum is written to the line buffer at index x>>1 (SRC_W/2 entries, synchronous read/write, not reset).
  - Odd y: the entry at x>>1 is read and added to the horizontal sums (R 7b, G 8b, B 7b).
- Output rounding: out = (sum+2)>>2 per component, giving R 5b, G 6b, B 5b. No saturation is needed.
- Output fields: wr_addr = (y>>1)*(SRC_W/2) + (x>>1); wr_data = {R,G,B}.
- The write counter (ADDR_W+1 bits, saturating) increments on each wr_en.
- frame_short = (count ≠ SRC_W*SRC_H/4), registered alongside frame_done. frame_count increments with frame_done.
- Missing even partner: an odd-x pixel with no even partner in the same row uses the stale pair register. This is not detected beyond frame_short.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_short=0, frame_count=0; state IDLE; pair register and counters 0.
- Even-row partial sum: written into the line buffer at T+1, where T is the accepted odd-x pixel cycle.
- Odd-x, odd-y pixel accepted at cycle T: wr_en high at T+2 for exactly one cycle. wr_addr and wr_data hold their values until the next write.
- Throughput: one accepted pixel per cycle must be sustained; upstream delivers at most one every two cycles.
- End of frame, where F is the first cycle with frame_valid sampled low in ACTIVE:
  - the last possible wr_en is at F+1;
  - frame_done and frame_short are high at F+2, and the count includes that write;
  - frame_count is updated at F+2.
- frame_valid high again during FLUSH: it is not honoured until IDLE is re-entered. The earliest new ACTIVE is entered at F+3 if frame_valid is sampled high at F+2.
- Reset asserted mid-frame: all outputs return to reset values immediately and no further writes occur. Pending pipeline writes are dropped.

## Test plan
- SRC_W=4, SRC_H=4; 16 pixels of 16'hFFFF → 4 writes, addr 0,1,2,3, data FFFF; frame_done at F+2, frame_short=0, frame_count=1.
- One 2x2 block with R=1,1,1,2, G=0,0,0,3, B=31,31,31,31 → wr_data R=1, G=1, B=31 (16'h083F), wr_en exactly T+2 after the 4th pixel.
- Pixels with pixel_x=SRC_W, pixel_y=SRC_H, pixel_valid while frame_valid=0, or in IDLE → no wr_en, line buffer unchanged, counts unaffected.
- frame_valid dropped after 2 of 4 rows (SRC 4x4) → 2 writes, frame_done with frame_short=1; next full frame gives frame_short=0, frame_count=2.
- 256 short frames → frame_count wraps to 0; rst_n pulsed mid-row → outputs 0 asynchronously, no wr_en after release until a new ACTIVE frame.
- Default 640x480 random frame vs. reference model → 76800 writes, last wr_addr=76799, all data matching.
